// File: rtl/result_arb_pkg.sv
// Shared types for the four-way result bus arbiter.
// Requester indices are 2 bits wide and wrap 3 -> 0.
package result_arb_pkg;

    localparam int N_REQ = 4;
    localparam int MUX_W = 64;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        ARB_EMPTY,
        ARB_FULL
    } arb_state_e;

    function automatic req_idx_t idx_inc(input req_idx_t i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/mux256_64.sv
// 4:1 mux over four packed 64-bit lanes (lane 0 in the low bits).
// Pure combinational datapath slice driven by the arbiter select.
module mux256_64 (
    input  logic [255:0] i_din,
    input  logic [1:0]   i_sel,
    output logic [63:0]  o_dout
);

    always_comb begin
        o_dout = i_din[63:0];
        unique case (i_sel)
            2'd0: o_dout = i_din[63:0];
            2'd1: o_dout = i_din[127:64];
            2'd2: o_dout = i_din[191:128];
            2'd3: o_dout = i_din[255:192];
            default: o_dout = i_din[63:0];
        endcase
    end

endmodule

// File: rtl/result_bus_arbiter_rr_pick4.sv
// Round-robin picker: first asserted request scanning ptr, ptr+1, ...
// When nothing is requested the index reports ptr itself.
module rr_pick4
    import result_arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  req_idx_t   i_ptr,
    output logic       o_gnt_valid,
    output req_idx_t   o_gnt_idx
);

    req_idx_t w_idx;

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = i_ptr;
        w_idx       = i_ptr;
        // Walk from the farthest slot back so the nearest one wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = i_ptr + req_idx_t'(k);
            if (i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin result bus arbiter with a one-entry registered output.
// Define ARB_BURST_EN to hold the grant across req_last-delimited bursts.
module result_bus_arbiter
    import result_arb_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        req_valid,
    input  logic [3:0]        req_last,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] req_data3,
    output logic [3:0]        req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready,
    output logic [1:0]        mux_sel
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    req_idx_t          r_ptr;
    logic [DATA_W-1:0] r_out_data;
    req_idx_t          r_out_src;

    logic [3:0]        w_cand;
    logic              w_gnt_valid;
    req_idx_t          w_gnt_idx;
    logic              w_can_accept;
    logic              w_xfer;
    logic [MUX_W-1:0]  w_mux_out;

`ifdef ARB_BURST_EN
    logic              r_lock;
    req_idx_t          r_lock_idx;

    // A locked burst masks everyone but the owner, even if it idles.
    always_comb begin
        w_cand = req_valid;
        if (r_lock) begin
            w_cand = req_valid & (4'b0001 << r_lock_idx);
        end
    end
`else
    logic              w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_cand        = req_valid;
`endif

    rr_pick4 u_pick (
        .i_req       (w_cand),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    mux256_64 u_mux (
        .i_din  ({req_data3, req_data2, req_data1, req_data0}),
        .i_sel  (w_gnt_idx),
        .o_dout (w_mux_out)
    );

    // Drain and refill may happen on the same edge.
    assign w_can_accept = (r_state == ARB_EMPTY) | (out_ready & out_valid);
    assign w_xfer       = reset_n & w_can_accept & w_gnt_valid;

    assign req_ready = w_xfer ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign mux_sel   = w_gnt_idx;
    assign out_valid = (r_state == ARB_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ARB_FULL;
                end
            end
            ARB_FULL: begin
                if (out_ready && !w_xfer) begin
                    w_state_nxt = ARB_EMPTY;
                end
            end
            default: w_state_nxt = ARB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data <= '0;
            r_out_src  <= '0;
        end else if (w_xfer) begin
            r_out_data <= w_mux_out;
            r_out_src  <= w_gnt_idx;
        end
    end

`ifdef ARB_BURST_EN
    // Pointer holds still mid-burst and advances past the owner at its end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= req_idx_t'(RR_INIT);
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_xfer) begin
            if (req_last[w_gnt_idx]) begin
                r_lock <= 1'b0;
                r_ptr  <= idx_inc(w_gnt_idx);
            end else begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_gnt_idx;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= req_idx_t'(RR_INIT);
        end else if (w_xfer) begin
            r_ptr <= idx_inc(w_gnt_idx);
        end
    end
`endif

endmodule
